sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
//
// PURPOSE
// Shares the single off-chip 16-bit SRAM between two requesters: the SLC-3 CPU
// port (MAR/MDR path driven by the control unit) and a DMA/loader port used for
// program load and memory inspection. Arbitrates round-robin, latches address and
// write data at grant, and drives the SRAM strobes through a fixed multi-cycle
// access. Returns read data and a one-cycle done pulse to the winning requester.
//
// PARAMETERS
// ADDR_W         20  SRAM address width
// DATA_W         16  SRAM data width
// ACCESS_CYCLES   3  cycles the strobes stay active per access; legal range 2..15
//
// PORTS
// Clk          in   1       clock
// Reset        in   1       synchronous, active-high reset
// cpu_req      in   1       CPU access request, level, held until cpu_done
// cpu_we       in   1       1 = write, 0 = read; sampled at grant
// cpu_addr     in   ADDR_W  CPU address; sampled at grant
// cpu_wdata    in   DATA_W  CPU write data; sampled at grant
// cpu_rdata    out  DATA_W  read data; valid in the cpu_done cycle, held until next CPU read completes
// cpu_done     out  1       one-cycle pulse, CPU access complete
// dma_req      in   1       DMA access request, level, held until dma_done
// dma_we       in   1       1 = write, 0 = read; sampled at grant
// dma_addr     in   ADDR_W  DMA address; sampled at grant
// dma_wdata    in   DATA_W  DMA write data; sampled at grant
// dma_rdata    out  DATA_W  read data; valid in the dma_done cycle, held until next DMA read completes
// dma_done     out  1       one-cycle pulse, DMA access complete
// sram_addr    out  ADDR_W  SRAM address, registered
// sram_ce_n    out  1       chip enable, active-low
// sram_oe_n    out  1       output enable, active-low
// sram_we_n    out  1       write enable, active-low
// sram_dq_out  out  DATA_W  write data toward the SRAM tristate buffer
// sram_dq_oe   out  1       1 = drive sram_dq_out onto the bus
// sram_dq_in   in   DATA_W  data read from the SRAM bus
//
// BEHAVIOUR
// - All outputs are registered. Reset values: strobes _n = 1, sram_dq_oe = 0,
//   done = 0, rdata = 0, sram_addr = 0. Round-robin pointer resets to CPU.
// - FSM states:
//   - IDLE: if any req is high, grant the winner, latch we/addr/wdata, and go to
//     ACCESS with cnt = 1. Otherwise stay in IDLE.
//   - ACCESS: cnt increments each cycle. Go to DONE after cnt == ACCESS_CYCLES.
//   - DONE: pulse the granted port's done, then go to IDLE.
// - Latency: req seen in IDLE at cycle 0; ACCESS spans cycles 1..N;
//   done = 1 in cycle N+1. N = ACCESS_CYCLES. The earliest next grant is in
//   cycle N+2 (IDLE sees req in N+1... the IDLE decision is made in cycle N+2).
// - Arbitration:
//   - Only one request high: that port wins.
//   - Both high: the port that was not granted last wins.
//   - The pointer updates only at grant.
// - Read access:
//   - ce_n = 0 and oe_n = 0 for all ACCESS cycles; we_n = 1; dq_oe = 0.
//   - rdata is captured from sram_dq_in at the end of the last ACCESS cycle.
//   - Only the granted port's rdata updates; the other port's rdata holds.
// - Write access:
//   - ce_n = 0 for all ACCESS cycles; oe_n = 1.
//   - we_n = 0 in ACCESS cycles 1..N-1 and 1 in cycle N, giving data hold time.
//   - dq_oe = 1 for all ACCESS cycles.
//   - rdata is unchanged.
// - DONE and IDLE: all strobes inactive and dq_oe = 0.
// - Dropping req mid-access is ignored. The access completes and done still
//   pulses.
// - A requester keeping req high after done is a new request; it is arbitrated
//   fresh in IDLE.
// - Changing addr/wdata/we after grant has no effect on the current access.
// - Reset mid-access: the next edge forces IDLE and reset values. No done is
//   issued, and the partial write is not retried.
// - Counter width is 4 bits. It clears on every grant, so it never wraps.
//
// TESTING
// 1. CPU read, ACCESS_CYCLES = 3: cpu_req = 1, addr = 0x00010, SRAM returns
//    0xBEEF -> oe_n low for cycles 1-3, cpu_done in cycle 4, cpu_rdata = 0xBEEF.
// 2. DMA write: addr = 0x00020, wdata = 0x1234 -> we_n low for cycles 1-2 and
//    high in cycle 3; dq_oe high for cycles 1-3; sram_dq_out = 0x1234;
//    dma_done in cycle 4.
// 3. Both request continuously after reset -> grant order CPU, DMA, CPU, DMA;
//    exactly one done pulse every 5 cycles.
// 4. cpu_addr changed to 0x00FFF in cycle 2 of an access to 0x00010 ->
//    sram_addr stays 0x00010 until DONE.
// 5. Reset asserted in cycle 2 of a write -> cycle 3 shows we_n = 1 and
//    dq_oe = 0; no cpu_done; the next request is served normally with the CPU
//    winning a tie.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM between the CPU and DMA ports.
// Each access holds the strobes for ACCESS_CYCLES cycles, then pulses the winner's done.
module sram_access_arbiter #(
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_done,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_in
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES);

   state_t            state_r, state_s;
   logic [3:0]        cnt_r, cnt_s;
   logic              gnt_dma_r, gnt_dma_s;
   logic              gnt_we_r, gnt_we_s;
   logic              prio_dma_r, prio_dma_s;
   logic              win_dma_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] dq_out_r, dq_out_s;
   logic              ce_n_r, ce_n_s;
   logic              oe_n_r, oe_n_s;
   logic              we_n_r, we_n_s;
   logic              dq_oe_r, dq_oe_s;
   logic              cpu_done_r, cpu_done_s;
   logic              dma_done_r, dma_done_s;
   logic [DATA_W-1:0] cpu_rdata_r, cpu_rdata_s;
   logic [DATA_W-1:0] dma_rdata_r, dma_rdata_s;

   // Next-state, grant and next-output logic; strobes are computed one cycle ahead so the registers line up with the access cycles.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      gnt_dma_s   = gnt_dma_r;
      gnt_we_s    = gnt_we_r;
      prio_dma_s  = prio_dma_r;
      win_dma_s   = 1'b0;
      addr_s      = addr_r;
      dq_out_s    = dq_out_r;
      ce_n_s      = 1'b1;
      oe_n_s      = 1'b1;
      we_n_s      = 1'b1;
      dq_oe_s     = 1'b0;
      cpu_done_s  = 1'b0;
      dma_done_s  = 1'b0;
      cpu_rdata_s = cpu_rdata_r;
      dma_rdata_s = dma_rdata_r;
      case (state_r)
         ST_IDLE: begin
            if (cpu_req || dma_req) begin
               win_dma_s  = dma_req && (!cpu_req || prio_dma_r);
               gnt_dma_s  = win_dma_s;
               gnt_we_s   = win_dma_s ? dma_we : cpu_we;
               addr_s     = win_dma_s ? dma_addr : cpu_addr;
               dq_out_s   = win_dma_s ? dma_wdata : cpu_wdata;
               prio_dma_s = !win_dma_s;
               cnt_s      = 4'd1;
               state_s    = ST_ACCESS;
               ce_n_s     = 1'b0;
               oe_n_s     = gnt_we_s;
               we_n_s     = !gnt_we_s;
               dq_oe_s    = gnt_we_s;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_r == LAST_CNT) begin
               state_s    = ST_DONE;
               cpu_done_s = !gnt_dma_r;
               dma_done_s = gnt_dma_r;
               if (!gnt_we_r) begin
                  if (gnt_dma_r) begin
                     dma_rdata_s = sram_dq_in;
                  end else begin
                     cpu_rdata_s = sram_dq_in;
                  end
               end else begin
                  cpu_rdata_s = cpu_rdata_r;
               end
            end else begin
               cnt_s   = cnt_r + 4'd1;
               ce_n_s  = 1'b0;
               oe_n_s  = gnt_we_r;
               dq_oe_s = gnt_we_r;
               // we_n rises for the final access cycle to give the SRAM data hold time.
               we_n_s  = !gnt_we_r || ((cnt_r + 4'd1) == LAST_CNT);
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, grant bookkeeping and registered output stage.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         gnt_dma_r   <= 1'b0;
         gnt_we_r    <= 1'b0;
         prio_dma_r  <= 1'b0;
         addr_r      <= {ADDR_W{1'b0}};
         dq_out_r    <= {DATA_W{1'b0}};
         ce_n_r      <= 1'b1;
         oe_n_r      <= 1'b1;
         we_n_r      <= 1'b1;
         dq_oe_r     <= 1'b0;
         cpu_done_r  <= 1'b0;
         dma_done_r  <= 1'b0;
         cpu_rdata_r <= {DATA_W{1'b0}};
         dma_rdata_r <= {DATA_W{1'b0}};
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         gnt_dma_r   <= gnt_dma_s;
         gnt_we_r    <= gnt_we_s;
         prio_dma_r  <= prio_dma_s;
         addr_r      <= addr_s;
         dq_out_r    <= dq_out_s;
         ce_n_r      <= ce_n_s;
         oe_n_r      <= oe_n_s;
         we_n_r      <= we_n_s;
         dq_oe_r     <= dq_oe_s;
         cpu_done_r  <= cpu_done_s;
         dma_done_r  <= dma_done_s;
         cpu_rdata_r <= cpu_rdata_s;
         dma_rdata_r <= dma_rdata_s;
      end
   end

   assign sram_addr   = addr_r;
   assign sram_dq_out = dq_out_r;
   assign sram_ce_n   = ce_n_r;
   assign sram_oe_n   = oe_n_r;
   assign sram_we_n   = we_n_r;
   assign sram_dq_oe  = dq_oe_r;
   assign cpu_done    = cpu_done_r;
   assign dma_done    = dma_done_r;
   assign cpu_rdata   = cpu_rdata_r;
   assign dma_rdata   = dma_rdata_r;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: stimulus pushes expected completions,
// a forked monitor pops and checks them whenever a done pulse appears.
module tb_sram_access_arbiter;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [19:0] cpu_addr = 20'd0;
   logic [15:0] cpu_wdata = 16'd0;
   logic [15:0] cpu_rdata;
   logic        cpu_done;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [19:0] dma_addr = 20'd0;
   logic [15:0] dma_wdata = 16'd0;
   logic [15:0] dma_rdata;
   logic        dma_done;
   logic [19:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
   logic [15:0] sram_dq_out, sram_dq_in;

   typedef struct {
      bit          port;
      bit          we;
      logic [15:0] rdata;
      int          cyc;
   } sb_t;

   sb_t         sb_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [15:0] exp_cpu = 16'd0;
   logic [15:0] exp_dma = 16'd0;

   sram_access_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_done(dma_done),
      .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in)
   );

   // SRAM read data is a fixed function of the address: 0x00010 reads 0xBEEF.
   assign sram_dq_in = sram_addr[15:0] + 16'hBEDF;

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit port, input bit we, input logic [15:0] rd, input int c);
      sb_t e;
      e.port = port; e.we = we; e.rdata = rd; e.cyc = c;
      sb_q.push_back(e);
   endtask

   task automatic monitor();
      sb_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (Reset) begin
            exp_cpu = 16'd0;
            exp_dma = 16'd0;
         end
         if (cpu_done || dma_done) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", {30'd0, dma_done, cpu_done}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.cyc));
               chk("done_port", {30'd0, dma_done, cpu_done}, e.port ? 32'd2 : 32'd1);
               if (!e.we) begin
                  if (e.port) exp_dma = e.rdata;
                  else        exp_cpu = e.rdata;
               end
               chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, exp_cpu});
               chk("dma_rdata", {16'd0, dma_rdata}, {16'd0, exp_dma});
            end
         end
      end
   endtask

   task automatic strobes(input string name, input bit ce, input bit oe, input bit we, input bit doe);
      chk({name, "_ce_n"}, {31'd0, sram_ce_n}, {31'd0, ce});
      chk({name, "_oe_n"}, {31'd0, sram_oe_n}, {31'd0, oe});
      chk({name, "_we_n"}, {31'd0, sram_we_n}, {31'd0, we});
      chk({name, "_dq_oe"}, {31'd0, sram_dq_oe}, {31'd0, doe});
   endtask

   initial begin
      int c;
      fork
         monitor();
      join_none

      // Reset values
      repeat (3) @(negedge Clk);
      strobes("reset", 1'b1, 1'b1, 1'b1, 1'b0);
      chk("reset_done", {30'd0, dma_done, cpu_done}, 32'd0);
      chk("reset_addr", {12'd0, sram_addr}, 32'd0);
      chk("reset_rdata", {cpu_rdata, dma_rdata}, 32'd0);
      Reset = 1'b0;

      // 1: CPU read of 0x00010 returning 0xBEEF
      @(negedge Clk);
      c = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
      push(1'b0, 1'b0, 16'hBEEF, c + 4);
      for (int k = 1; k <= 3; k++) begin
         @(negedge Clk);
         strobes("t1_read", 1'b0, 1'b0, 1'b1, 1'b0);
         chk("t1_addr", {12'd0, sram_addr}, 32'h00010);
      end
      @(negedge Clk);
      cpu_req = 1'b0;
      strobes("t1_done", 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge Clk);

      // 2: DMA write of 0x1234 to 0x00020
      c = cyc;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 20'h00020; dma_wdata = 16'h1234;
      push(1'b1, 1'b1, 16'h0000, c + 4);
      for (int k = 1; k <= 3; k++) begin
         @(negedge Clk);
         strobes("t2_write", 1'b0, 1'b1, (k == 3), 1'b1);
         chk("t2_dq_out", {16'd0, sram_dq_out}, 32'h1234);
         chk("t2_addr", {12'd0, sram_addr}, 32'h00020);
      end
      @(negedge Clk);
      dma_req = 1'b0; dma_we = 1'b0;
      strobes("t2_done", 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge Clk);

      // 3: both request continuously after reset -> CPU, DMA, CPU, DMA every 5 cycles
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      c = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00100;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 20'h00200;
      push(1'b0, 1'b0, 16'hBFDF, c + 4);
      push(1'b1, 1'b0, 16'hC0DF, c + 9);
      push(1'b0, 1'b0, 16'hBFDF, c + 14);
      push(1'b1, 1'b0, 16'hC0DF, c + 19);
      repeat (19) @(negedge Clk);
      cpu_req = 1'b0; dma_req = 1'b0;
      repeat (3) @(negedge Clk);

      // 4: address changed after grant has no effect
      c = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
      push(1'b0, 1'b0, 16'hBEEF, c + 4);
      for (int k = 1; k <= 4; k++) begin
         @(negedge Clk);
         if (k == 2) cpu_addr = 20'h00FFF;
         chk("t4_addr_hold", {12'd0, sram_addr}, 32'h00010);
      end
      cpu_req = 1'b0;
      repeat (2) @(negedge Clk);

      // 5: reset in cycle 2 of a CPU write, then a tie goes to CPU
      c = cyc;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00030; cpu_wdata = 16'h5555;
      @(negedge Clk);
      strobes("t5_cyc1", 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      strobes("t5_after_reset", 1'b1, 1'b1, 1'b1, 1'b0);
      Reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge Clk);
      c = cyc;
      cpu_req = 1'b1; cpu_addr = 20'h00040;
      dma_req = 1'b1; dma_addr = 20'h00050;
      push(1'b0, 1'b0, 16'hBF1F, c + 4);
      push(1'b1, 1'b0, 16'hBF2F, c + 9);
      repeat (4) @(negedge Clk);
      cpu_req = 1'b0;
      repeat (5) @(negedge Clk);
      dma_req = 1'b0;
      repeat (4) @(negedge Clk);

      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
